// File: rtl/dl11_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dl11_regs                                                     |
// | Purpose  : PDP-11 console serial-line register block (DL11 subset).      |
// |            Presents RCSR/RBUF/XCSR/XBUF to the CPU and runs four-phase   |
// |            load/unload handshakes with an asynchronous uart.             |
// |            Raises level interrupt requests for receiver done and         |
// |            transmitter ready.                                            |
// | Ports    : clk, reset (async, active-low)                                |
// |            addr/rd/wr/data_in/data_out   - CPU register access           |
// |            rx_irq/tx_irq                 - level interrupt requests      |
// |            ld_tx_req/ld_tx_ack/tx_data/tx_empty      - uart transmit side|
// |            uld_rx_req/uld_rx_ack/rx_data/rx_empty    - uart receive side |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dl11_regs #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        rx_irq,
  output logic        tx_irq,
  output logic        ld_tx_req,
  input  logic        ld_tx_ack,
  output logic [7:0]  tx_data,
  input  logic        tx_empty,
  output logic        uld_rx_req,
  input  logic        uld_rx_ack,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty
);

  // A single flop is not a synchroniser; floor the depth at two.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [1:0] ADDR_RCSR = 2'd0;
  localparam logic [1:0] ADDR_RBUF = 2'd1;
  localparam logic [1:0] ADDR_XCSR = 2'd2;
  localparam logic [1:0] ADDR_XBUF = 2'd3;

  // Synchroniser lanes: {tx_empty, rx_empty, uld_rx_ack, ld_tx_ack}.
  // The empties come out of reset as 1 so nothing is fetched or completed
  // before the uart has actually been sampled.
  localparam logic [3:0] SYNC_RESET = 4'b1100;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_REQ  = 2'd1,
    RX_DROP = 2'd2,
    RX_CAP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_DROP = 2'd2,
    TX_WAIT = 2'd3
  } tx_state_e;

  logic [STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]             sync_s;
  logic                   tx_ack_s, rx_ack_s, rx_empty_s, tx_empty_s;

  rx_state_e   rx_state_q, rx_state_d;
  tx_state_e   tx_state_q, tx_state_d;

  logic [15:0] data_out_q, data_out_d;
  logic        rx_irq_q, rx_irq_d;
  logic        tx_irq_q, tx_irq_d;
  logic        ld_tx_req_q, ld_tx_req_d;
  logic        uld_rx_req_q, uld_rx_req_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic        rdone_q, rdone_d;
  logic        rie_q, rie_d;
  logic        tready_q, tready_d;
  logic        tie_q, tie_d;

  logic        rd_en;
  logic        xbuf_accept;
  logic        unused_data_bits;

  assign sync_s     = sync_q[STAGES-1];
  assign tx_ack_s   = sync_s[0];
  assign rx_ack_s   = sync_s[1];
  assign rx_empty_s = sync_s[2];
  assign tx_empty_s = sync_s[3];

  // A simultaneous write suppresses the read entirely.
  assign rd_en       = rd & ~wr;
  assign xbuf_accept = wr & (addr == ADDR_XBUF) & tready_q;

  assign unused_data_bits = ^{data_in[15:8], data_in[5:0]};

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], {tx_empty, rx_empty, uld_rx_ack, ld_tx_ack}};
  end

  always_comb begin
    data_out_d   = data_out_q;
    rx_state_d   = rx_state_q;
    tx_state_d   = tx_state_q;
    ld_tx_req_d  = ld_tx_req_q;
    uld_rx_req_d = uld_rx_req_q;
    tx_data_d    = tx_data_q;
    rbuf_d       = rbuf_q;
    rdone_d      = rdone_q;
    rie_d        = rie_q;
    tready_d     = tready_q;
    tie_d        = tie_q;

    // CPU writes
    if (wr) begin
      case (addr)
        ADDR_RCSR: rie_d = data_in[6];
        ADDR_XCSR: tie_d = data_in[6];
        ADDR_XBUF: begin
          if (tready_q) begin
            tx_data_d = data_in[7:0];
            tready_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // CPU reads
    if (rd_en) begin
      case (addr)
        ADDR_RCSR: data_out_d = {8'h00, rdone_q, rie_q, 6'h00};
        ADDR_RBUF: begin
          data_out_d = {8'h00, rbuf_q};
          rdone_d    = 1'b0;
        end
        ADDR_XCSR: data_out_d = {8'h00, tready_q, tie_q, 6'h00};
        default:   data_out_d = 16'h0000;
      endcase
    end

    // Receive unload handshake. Placed after the read decode so a capture
    // in the same cycle as an RBUF read leaves rdone set.
    case (rx_state_q)
      RX_IDLE: begin
        if (!rdone_q && !rx_empty_s) begin
          uld_rx_req_d = 1'b1;
          rx_state_d   = RX_REQ;
        end
      end
      RX_REQ: begin
        if (rx_ack_s) begin
          uld_rx_req_d = 1'b0;
          rx_state_d   = RX_DROP;
        end
      end
      RX_DROP: begin
        if (!rx_ack_s) rx_state_d = RX_CAP;
      end
      RX_CAP: begin
        // rx_data has been stable since the uart dropped its ack.
        rbuf_d     = rx_data;
        rdone_d    = 1'b1;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // Transmit load handshake
    case (tx_state_q)
      TX_IDLE: begin
        if (xbuf_accept) begin
          ld_tx_req_d = 1'b1;
          tx_state_d  = TX_REQ;
        end
      end
      TX_REQ: begin
        if (tx_ack_s) begin
          ld_tx_req_d = 1'b0;
          tx_state_d  = TX_DROP;
        end
      end
      TX_DROP: begin
        if (!tx_ack_s) tx_state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_empty_s) begin
          tready_d   = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Interrupts follow their sources by one clock.
    rx_irq_d = rdone_q & rie_q;
    tx_irq_d = tready_q & tie_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= {STAGES{SYNC_RESET}};
      rx_state_q   <= RX_IDLE;
      tx_state_q   <= TX_IDLE;
      data_out_q   <= 16'h0000;
      rx_irq_q     <= 1'b0;
      tx_irq_q     <= 1'b0;
      ld_tx_req_q  <= 1'b0;
      uld_rx_req_q <= 1'b0;
      tx_data_q    <= 8'h00;
      rbuf_q       <= 8'h00;
      rdone_q      <= 1'b0;
      rie_q        <= 1'b0;
      tready_q     <= 1'b1;
      tie_q        <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      rx_state_q   <= rx_state_d;
      tx_state_q   <= tx_state_d;
      data_out_q   <= data_out_d;
      rx_irq_q     <= rx_irq_d;
      tx_irq_q     <= tx_irq_d;
      ld_tx_req_q  <= ld_tx_req_d;
      uld_rx_req_q <= uld_rx_req_d;
      tx_data_q    <= tx_data_d;
      rbuf_q       <= rbuf_d;
      rdone_q      <= rdone_d;
      rie_q        <= rie_d;
      tready_q     <= tready_d;
      tie_q        <= tie_d;
    end
  end

  assign data_out   = data_out_q;
  assign rx_irq     = rx_irq_q;
  assign tx_irq     = tx_irq_q;
  assign ld_tx_req  = ld_tx_req_q;
  assign uld_rx_req = uld_rx_req_q;
  assign tx_data    = tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_dl11_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dl11_regs                                                  |
// | Purpose  : Self-checking bench for dl11_regs with behavioural uart       |
// |            responders and a register-level reference model.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dl11_regs;

  localparam int SYNC_STAGES = 2;
  localparam logic [1:0] A_RCSR = 2'd0;
  localparam logic [1:0] A_RBUF = 2'd1;
  localparam logic [1:0] A_XCSR = 2'd2;
  localparam logic [1:0] A_XBUF = 2'd3;

  logic        clk, reset;
  logic [1:0]  addr;
  logic        rd, wr;
  logic [15:0] data_in, data_out;
  logic        rx_irq, tx_irq;
  logic        ld_tx_req, ld_tx_ack, tx_empty;
  logic [7:0]  tx_data;
  logic        uld_rx_req, uld_rx_ack, rx_empty;
  logic [7:0]  rx_data;

  dl11_regs #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr),
    .data_in(data_in), .data_out(data_out), .rx_irq(rx_irq), .tx_irq(tx_irq),
    .ld_tx_req(ld_tx_req), .ld_tx_ack(ld_tx_ack), .tx_data(tx_data),
    .tx_empty(tx_empty), .uld_rx_req(uld_rx_req), .uld_rx_ack(uld_rx_ack),
    .rx_data(rx_data), .rx_empty(rx_empty)
  );

  int checks   = 0;
  int failures = 0;

  // uart-side bookkeeping
  logic [7:0] rx_q[$];     // characters waiting in the uart receiver
  logic [7:0] tx_log[$];   // characters the uart transmitter has loaded
  int         tx_loads   = 0;
  int         uld_pulses = 0;
  int         tx_req_lat = 0;
  bit         rx_drop_flag = 1'b0;

  // reference model of the CPU-visible state
  bit         m_rie, m_tie;
  logic [7:0] m_rbuf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin @(posedge ld_tx_req);  tx_loads++;   end
  initial forever begin @(posedge uld_rx_req); uld_pulses++; end

  // uart transmitter: ack after a few clocks, drop once req falls,
  // report the holding register empty again some time later.
  initial begin
    int lat;
    ld_tx_ack = 1'b0;
    tx_empty  = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ld_tx_req === 1'b1) begin
        tx_log.push_back(tx_data);
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        ld_tx_ack = 1'b1;
        tx_empty  = 1'b0;
        lat = 0;
        while (ld_tx_req === 1'b1 && lat < 50) begin
          @(posedge clk); #1;
          lat++;
        end
        tx_req_lat = lat;
        ld_tx_ack  = 1'b0;
        repeat ($urandom_range(5, 25)) @(posedge clk);
        #1;
        tx_empty = 1'b1;
      end
    end
  end

  // uart receiver: presents the head character with its ack and keeps
  // rx_data stable after the ack drops.
  initial begin
    int n;
    uld_rx_ack = 1'b0;
    rx_empty   = 1'b1;
    rx_data    = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (uld_rx_req === 1'b1 && rx_q.size() > 0) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        rx_data    = rx_q[0];
        uld_rx_ack = 1'b1;
        n = 0;
        while (uld_rx_req === 1'b1 && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        uld_rx_ack = 1'b0;
        void'(rx_q.pop_front());
        rx_empty     = (rx_q.size() == 0);
        rx_drop_flag = 1'b1;
      end
    end
  end

  function automatic logic [15:0] csr(input bit done, input bit ie);
    return {8'h00, done, ie, 6'h00};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    addr = a; data_in = d; wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] v);
    addr = a; rd = 1'b1;
    cyc();
    rd = 1'b0;
    v = data_out;
  endtask

  // Poll a status register until its done/ready bit reads 1.
  task automatic poll_done(input logic [1:0] a, input string tag, output logic [15:0] v);
    int n;
    n = 0;
    v = 16'h0000;
    while (v[7] !== 1'b1 && n < 400) begin
      bus_read(a, v);
      n++;
    end
    check(tag, {15'h0000, v[7]}, 16'h0001);
  endtask

  function automatic logic [15:0] pop_tx();
    if (tx_log.size() == 0) return 16'hFFFF;
    return {8'h00, tx_log.pop_front()};
  endfunction

  initial begin
    logic [15:0] v;
    logic [7:0]  ca, cb, cc;
    int          p0, t0;
    bit          got;

    reset = 1'b0; addr = 2'd0; rd = 1'b0; wr = 1'b0; data_in = 16'h0000;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    cyc();
    check("por_data_out", data_out, 16'h0000);
    check("por_irqs", {14'h0, rx_irq, tx_irq}, 16'h0000);
    check("por_reqs", {14'h0, ld_tx_req, uld_rx_req}, 16'h0000);

    // Build up state, then hit reset in the middle of a cycle mid-handshake.
    bus_write(A_RCSR, 16'h0040);
    bus_write(A_XCSR, 16'h0040);
    bus_read(A_XCSR, v);
    check("pre_xcsr", v, 16'h00C0);
    bus_write(A_XBUF, 16'h0033);
    check("pre_ld_req", {15'h0, ld_tx_req}, 16'h0001);
    #1 reset = 1'b0;
    #1;
    check("rst_ld_req", {15'h0, ld_tx_req}, 16'h0000);
    check("rst_data_out", data_out, 16'h0000);
    check("rst_tx_data", {8'h00, tx_data}, 16'h0000);
    check("rst_irqs", {14'h0, rx_irq, tx_irq}, 16'h0000);
    #1 reset = 1'b1;
    repeat (60) cyc();
    tx_log.delete();
    tx_loads = 0; uld_pulses = 0;
    m_rie = 1'b0; m_tie = 1'b0; m_rbuf = 8'h00;

    bus_read(A_XCSR, v);
    check("rst_xcsr", v, csr(1'b1, m_tie));
    bus_read(A_RCSR, v);
    check("rst_rcsr", v, csr(1'b0, m_rie));

    // ---- transmit ----
    bus_write(A_XCSR, 16'h0040); m_tie = 1'b1;
    bus_write(A_XBUF, 16'h0141);
    check("tx_data", {8'h00, tx_data}, 16'h0041);
    check("tx_ld_req", {15'h0, ld_tx_req}, 16'h0001);
    bus_write(A_XBUF, 16'h0042);   // rejected: transmitter busy
    check("tx_irq_busy", {15'h0, tx_irq}, 16'h0000);
    check("tx_data_busy", {8'h00, tx_data}, 16'h0041);
    bus_read(A_XCSR, v);
    check("xcsr_busy", v, csr(1'b0, m_tie));
    t0 = 0;
    while (tx_irq !== 1'b1 && t0 < 400) begin cyc(); t0++; end
    check("tx_irq_done", {15'h0, tx_irq}, 16'h0001);
    check("tx_loads", 16'(tx_loads), 16'd1);
    check("tx_char", pop_tx(), 16'h0041);
    check("tx_req_lat", 16'(tx_req_lat), 16'(SYNC_STAGES + 1));
    repeat (40) cyc();
    check("tx_single", 16'(tx_loads), 16'd1);
    bus_read(A_XCSR, v);
    check("xcsr_done", v, csr(1'b1, m_tie));

    // ---- receive ----
    p0 = uld_pulses;
    rx_q.push_back(8'h5A); rx_empty = 1'b0;
    poll_done(A_RCSR, "rx_done_wait", v);
    check("rcsr_done", v, csr(1'b1, m_rie));
    cyc(); cyc();
    check("rx_irq_off", {15'h0, rx_irq}, 16'h0000);
    check("rx_pulses", 16'(uld_pulses - p0), 16'd1);
    bus_read(A_RBUF, v); m_rbuf = 8'h5A;
    check("rbuf_5a", v, {8'h00, m_rbuf});
    bus_read(A_RCSR, v);
    check("rcsr_clear", v, csr(1'b0, m_rie));

    // ---- receive hold-off while rdone=1 ----
    bus_write(A_RCSR, 16'hFF40); m_rie = 1'b1;
    ca = 8'($urandom_range(0, 255));
    cb = 8'($urandom_range(0, 255));
    p0 = uld_pulses;
    rx_q.push_back(ca); rx_q.push_back(cb); rx_empty = 1'b0;
    poll_done(A_RCSR, "hold_wait", v);
    repeat (30) cyc();
    check("hold_pulses", 16'(uld_pulses - p0), 16'd1);
    check("hold_irq", {15'h0, rx_irq}, 16'h0001);
    bus_read(A_RBUF, v); m_rbuf = ca;
    check("hold_rbuf_a", v, {8'h00, m_rbuf});
    poll_done(A_RCSR, "hold_wait2", v);
    check("hold_pulses2", 16'(uld_pulses - p0), 16'd2);
    bus_read(A_RBUF, v); m_rbuf = cb;
    check("hold_rbuf_b", v, {8'h00, m_rbuf});
    cyc(); cyc();
    check("hold_irq_off", {15'h0, rx_irq}, 16'h0000);

    // ---- RBUF read landing on the capture cycle ----
    cc = 8'($urandom_range(0, 255));
    rx_drop_flag = 1'b0;
    rx_q.push_back(cc); rx_empty = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      cyc();
      got = rx_drop_flag;
    end
    check("coll_drop_seen", {15'h0, got}, 16'h0001);
    // ack low is seen after SYNC_STAGES clocks, then one clock to enter capture.
    repeat (SYNC_STAGES + 1) cyc();
    bus_read(A_RBUF, v);
    check("coll_rbuf_old", v, {8'h00, m_rbuf});
    bus_read(A_RCSR, v);
    check("coll_rcsr", v, csr(1'b1, m_rie));
    bus_read(A_RBUF, v); m_rbuf = cc;
    check("coll_rbuf_new", v, {8'h00, m_rbuf});

    // rd and wr together on XCSR: write takes effect, data_out holds.
    addr = A_XCSR; rd = 1'b1; wr = 1'b1; data_in = {9'h000, ~m_tie, 6'h00};
    cyc();
    rd = 1'b0; wr = 1'b0; m_tie = ~m_tie;
    check("rdwr_hold", data_out, {8'h00, m_rbuf});
    bus_read(A_XCSR, v);
    check("rdwr_tie", v, csr(1'b1, m_tie));

    // ---- randomized traffic ----
    for (int i = 0; i < 6; i++) begin
      logic [15:0] r;
      logic [7:0]  c;
      r = 16'($urandom);
      bus_write(A_RCSR, r); m_rie = r[6];
      r = 16'($urandom);
      bus_write(A_XCSR, r); m_tie = r[6];

      c  = 8'($urandom_range(0, 255));
      t0 = tx_loads;
      bus_write(A_XBUF, {8'($urandom), c});
      poll_done(A_XCSR, "rnd_tx_wait", v);
      check("rnd_xcsr", v, csr(1'b1, m_tie));
      check("rnd_tx_char", pop_tx(), {8'h00, c});
      check("rnd_tx_loads", 16'(tx_loads - t0), 16'd1);
      cyc(); cyc();
      check("rnd_tx_irq", {15'h0, tx_irq}, {15'h0, m_tie});

      c = 8'($urandom_range(0, 255));
      rx_q.push_back(c); rx_empty = 1'b0;
      poll_done(A_RCSR, "rnd_rx_wait", v);
      check("rnd_rcsr", v, csr(1'b1, m_rie));
      cyc(); cyc();
      check("rnd_rx_irq", {15'h0, rx_irq}, {15'h0, m_rie});
      bus_read(A_RBUF, v); m_rbuf = c;
      check("rnd_rbuf", v, {8'h00, m_rbuf});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dl11_regs.md
Name: dl11_regs

Overview:
- PDP-11 console serial-line register interface (DL11 subset); sits between the Unibus slave decode and the async uart.
- Presents RCSR/RBUF/XCSR/XBUF to the CPU.
- Drives the uart's four-phase load/unload handshakes, whose acks originate in the uart's txclk/rxclk domains.
- Raises level interrupt requests for receiver done and transmitter ready.

Parameters:
- SYNC_STAGES, 2, flops in each synchroniser on ld_tx_ack, uld_rx_ack, tx_empty, rx_empty (minimum 2).

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- addr  in  2  word offset: 0 RCSR, 1 RBUF, 2 XCSR, 3 XBUF (177560..177566)
- rd  in  1  read strobe, one clk
- wr  in  1  write strobe, one clk
- data_in  in  16  write data
- data_out  out  16  read data, registered
- rx_irq  out  1  receiver interrupt request, level
- tx_irq  out  1  transmitter interrupt request, level
- ld_tx_req  out  1  load request to uart tx
- ld_tx_ack  in  1  uart tx load ack, async
- tx_data  out  8  character to uart tx
- tx_empty  in  1  uart tx holding empty, async
- uld_rx_req  out  1  unload request to uart rx
- uld_rx_ack  in  1  uart rx unload ack, async
- rx_data  in  8  character from uart rx, stable after ack deasserts
- rx_empty  in  1  uart rx holding empty, async

Behaviour:
- Reset (reset=0, async) sets:
  - rdone=0, rie=0, rbuf=0
  - tready=1, tie=0, tx_data=0
  - ld_tx_req=0, uld_rx_req=0
  - data_out=0, rx_irq=0, tx_irq=0
  - both FSMs IDLE; synchronisers cleared (empties preset to 1).
- Reset mid-handshake drops the requests immediately; the uart returns to idle on its own once req is low.
- Synchroniser outputs (ack_s, empty_s) are the only form of async inputs the FSMs use; rx_data is sampled only in RX_CAP.

Register read (data_out loaded the clk after rd, held until the next rd):
- RCSR: bit7=rdone, bit6=rie, others 0.
- RBUF: [7:0]=rbuf, others 0. rdone clears on the rd cycle.
- XCSR: bit7=tready, bit6=tie, others 0.
- XBUF: reads 0.
- rd and wr in the same cycle: write wins, data_out unchanged.

Register write:
- RCSR: rie<=data_in[6]; other bits ignored.
- XCSR: tie<=data_in[6].
- RBUF: ignored.
- XBUF while tready=1: tx_data<=data_in[7:0], tready<=0, tx FSM starts.
- XBUF while tready=0: ignored, no state change.

RX FSM:
- RX_IDLE: rdone=0 and rx_empty_s=0 -> uld_rx_req<=1, go RX_REQ.
- RX_REQ: ack_s=1 -> uld_rx_req<=0, go RX_DROP.
- RX_DROP: ack_s=0 -> go RX_CAP.
- RX_CAP: rbuf<=rx_data, rdone<=1, go RX_IDLE.
- No fetch while rdone=1; the uart holds the char and flags its own overrun.
- RBUF read in the same cycle as RX_CAP: capture wins, so rdone ends at 1.

TX FSM:
- TX_IDLE: accepted XBUF write -> ld_tx_req<=1, go TX_REQ.
- TX_REQ: ack_s=1 -> ld_tx_req<=0, go TX_DROP.
- TX_DROP: ack_s=0 -> go TX_WAIT.
- TX_WAIT: tx_empty_s=1 -> tready<=1, go TX_IDLE.

Interrupts (registered one clk after the source changes):
- rx_irq = rdone & rie.
- tx_irq = tready & tie.

Test Plan:
- Reset: pulse reset=0 mid-cycle -> data_out=0, ld_tx_req=0, uld_rx_req=0, irqs 0; read XCSR -> 0x0080, read RCSR -> 0x0000.
- TX: write XCSR=0x0040, XBUF=0x0141 -> tx_data=0x41, tready=0, tx_irq=0, ld_tx_req=1.
  - Model ack after 3 clk, drop after req low, tx_empty low then high after 20 clk.
  - Expect req low one synchroniser delay after ack; tready=1 and tx_irq=1 after tx_empty rises.
- TX busy write: second XBUF write 0x42 while tready=0 -> tx_data stays 0x41, only one handshake occurs.
- RX: rx_data=0x5A, rx_empty=0; model ack/drop -> exactly one uld_rx_req pulse.
  - RCSR reads 0x0080 (rie=0, rx_irq=0).
  - RBUF read -> data_out=0x005A, then RCSR reads 0x0000.
- RX hold-off: rx_empty stays 0 with a second char while rdone=1 -> no uld_rx_req until RBUF is read; then exactly one fetch.
- Collision: RBUF rd in the same cycle as RX_CAP -> rdone=1 afterwards; rd and wr together on XCSR -> tie updated, data_out unchanged.
